// File: rtl/axi_decerr_slave_pkg.sv
// Shared definitions for the default-port DECERR responder: SoC constants, AXI
// channel structs and a small helper used by both the read and the write path.
package ariane_soc;
  localparam int unsigned IdWidthSlave  = 5;
  localparam logic [1:0]  AxiRespDecErr = 2'b11;
  localparam logic [63:0] DecErrRData   = 64'hBADC_AB1E_DEAD_BEEF;
endpackage

package ariane_axi;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdWidth   = ariane_soc::IdWidthSlave;
  localparam int unsigned UserWidth = 1;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;
  typedef logic [UserWidth-1:0] user_t;

  typedef struct packed {
    id_t          id;
    addr_t        addr;
    logic [7:0]   len;
    logic [2:0]   size;
    logic [1:0]   burst;
    logic         lock;
    logic [3:0]   cache;
    logic [2:0]   prot;
    logic [3:0]   qos;
    logic [3:0]   region;
    logic [5:0]   atop;
    user_t        user;
  } aw_chan_t;

  typedef struct packed {
    data_t        data;
    strb_t        strb;
    logic         last;
    user_t        user;
  } w_chan_t;

  typedef struct packed {
    id_t          id;
    logic [1:0]   resp;
    user_t        user;
  } b_chan_t;

  typedef struct packed {
    id_t          id;
    addr_t        addr;
    logic [7:0]   len;
    logic [2:0]   size;
    logic [1:0]   burst;
    logic         lock;
    logic [3:0]   cache;
    logic [2:0]   prot;
    logic [3:0]   qos;
    logic [3:0]   region;
    user_t        user;
  } ar_chan_t;

  typedef struct packed {
    id_t          id;
    data_t        data;
    logic [1:0]   resp;
    logic         last;
    user_t        user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t     aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    ar_chan_t     ar;
    logic         ar_valid;
    logic         r_ready;
  } req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    b_chan_t      b;
    logic         r_valid;
    r_chan_t      r;
  } resp_t;
endpackage

package axi_decerr_slave_pkg;
  localparam int unsigned BeatCntWidth = 8;

  // Response code is only driven while the channel is valid so idle payloads read as 0.
  function automatic logic [1:0] decerr_resp(input logic vld);
    return vld ? ariane_soc::AxiRespDecErr : 2'b00;
  endfunction
endpackage

// File: rtl/axi_decerr_r_chan.sv
// Read half of the DECERR responder: accepts one AR at a time and returns
// len+1 constant-data beats, each flagged DECERR, with last on the final beat.
module axi_decerr_r_chan
  import axi_decerr_slave_pkg::*;
#(
  parameter int unsigned         IdWidth      = 5,
  parameter int unsigned         DataWidth    = 64,
  parameter logic [DataWidth-1:0] RDataPattern = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ar_valid,
  input  logic [IdWidth-1:0]      i_ar_id,
  input  logic [BeatCntWidth-1:0] i_ar_len,
  output logic                    o_ar_ready,
  output logic                    o_ar_hs,
  input  logic                    i_r_ready,
  output logic                    o_r_valid,
  output logic [IdWidth-1:0]      o_r_id,
  output logic [DataWidth-1:0]    o_r_data,
  output logic [1:0]              o_r_resp,
  output logic                    o_r_last
);

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [0:0]              r_state;
  logic [0:0]              w_state_nxt;
  logic                    r_ar_ready;
  logic                    r_r_valid;
  logic [IdWidth-1:0]      r_id;
  logic [BeatCntWidth-1:0] r_cnt;
  logic                    w_ar_hs;
  logic                    w_r_hs;
  logic                    w_r_last;

  assign w_ar_hs  = i_ar_valid & r_ar_ready;
  assign w_r_hs   = r_r_valid & i_r_ready;
  assign w_r_last = r_r_valid & (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (w_ar_hs) w_state_nxt = R_DATA;
      R_DATA:  if (w_r_hs && w_r_last) w_state_nxt = R_IDLE;
      default: w_state_nxt = R_IDLE;
    endcase
  end

  // Ready/valid are registered decodes of the next state, so they stay low in reset
  // and an accept is always followed by at least one cycle of ready=0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= R_IDLE;
      r_ar_ready <= 1'b0;
      r_r_valid  <= 1'b0;
      r_id       <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ar_ready <= (w_state_nxt == R_IDLE);
      r_r_valid  <= (w_state_nxt == R_DATA);
      if (w_ar_hs) begin
        r_id  <= i_ar_id;
        r_cnt <= i_ar_len;
      end else if (w_r_hs && !w_r_last) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_ar_ready = r_ar_ready;
  assign o_ar_hs    = w_ar_hs;
  assign o_r_valid  = r_r_valid;
  assign o_r_id     = r_id;
  assign o_r_data   = r_r_valid ? RDataPattern : '0;
  assign o_r_resp   = decerr_resp(r_r_valid);
  assign o_r_last   = w_r_last;

endmodule

// File: rtl/axi_decerr_slave.sv
// AXI4 default-port responder: every read and write completes with DECERR.
// Optional first-fault address log enabled by defining AXI_DECERR_LOG_EN.
module axi_decerr_slave
  import ariane_axi::*;
  import axi_decerr_slave_pkg::*;
#(
  parameter int unsigned          IdWidth      = ariane_soc::IdWidthSlave,
  parameter int unsigned          DataWidth    = 64,
  parameter logic [DataWidth-1:0] RDataPattern = ariane_soc::DecErrRData
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  req_t        axi_req_i,
  output resp_t       axi_resp_o,
  output logic        err_valid_o,
  output logic [63:0] err_addr_o,
  input  logic        err_clear_i
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [1:0]           r_w_state;
  logic [1:0]           w_w_state_nxt;
  logic                 r_aw_ready;
  logic                 r_w_ready;
  logic                 r_b_valid;
  logic [IdWidth-1:0]   r_b_id;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_b_hs;

  logic                 w_ar_ready;
  logic                 w_ar_hs;
  logic                 w_r_valid;
  logic [IdWidth-1:0]   w_r_id;
  logic [DataWidth-1:0] w_r_data;
  logic [1:0]           w_r_resp;
  logic                 w_r_last;
  logic                 w_unused;

  assign w_aw_hs = axi_req_i.aw_valid & r_aw_ready;
  assign w_w_hs  = axi_req_i.w_valid & r_w_ready;
  assign w_b_hs  = r_b_valid & axi_req_i.b_ready;

  // W data, strobes and aw.len/atop are deliberately ignored; w.last alone ends the burst.
  always_comb begin
    w_w_state_nxt = r_w_state;
    case (r_w_state)
      W_IDLE:  if (w_aw_hs) w_w_state_nxt = W_DATA;
      W_DATA:  if (w_w_hs && axi_req_i.w.last) w_w_state_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_w_state_nxt = W_IDLE;
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_w_state  <= W_IDLE;
      r_aw_ready <= 1'b0;
      r_w_ready  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_b_id     <= '0;
    end else begin
      r_w_state  <= w_w_state_nxt;
      r_aw_ready <= (w_w_state_nxt == W_IDLE);
      r_w_ready  <= (w_w_state_nxt == W_DATA);
      r_b_valid  <= (w_w_state_nxt == W_RESP);
      if (w_aw_hs) r_b_id <= axi_req_i.aw.id;
    end
  end

  axi_decerr_r_chan #(
    .IdWidth      (IdWidth),
    .DataWidth    (DataWidth),
    .RDataPattern (RDataPattern)
  ) u_r_chan (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_ar_valid (axi_req_i.ar_valid),
    .i_ar_id    (axi_req_i.ar.id),
    .i_ar_len   (axi_req_i.ar.len),
    .o_ar_ready (w_ar_ready),
    .o_ar_hs    (w_ar_hs),
    .i_r_ready  (axi_req_i.r_ready),
    .o_r_valid  (w_r_valid),
    .o_r_id     (w_r_id),
    .o_r_data   (w_r_data),
    .o_r_resp   (w_r_resp),
    .o_r_last   (w_r_last)
  );

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = r_aw_ready;
    axi_resp_o.w_ready  = r_w_ready;
    axi_resp_o.b_valid  = r_b_valid;
    axi_resp_o.b.id     = r_b_id;
    axi_resp_o.b.resp   = decerr_resp(r_b_valid);
    axi_resp_o.ar_ready = w_ar_ready;
    axi_resp_o.r_valid  = w_r_valid;
    axi_resp_o.r.id     = w_r_id;
    axi_resp_o.r.data   = w_r_data;
    axi_resp_o.r.resp   = w_r_resp;
    axi_resp_o.r.last   = w_r_last;
  end

`ifdef AXI_DECERR_LOG_EN
  logic        r_err_valid;
  logic [63:0] r_err_addr;

  // Clear beats capture; a simultaneous AR and AW accept logs the read address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (err_clear_i) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (!r_err_valid && (w_ar_hs || w_aw_hs)) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= w_ar_hs ? axi_req_i.ar.addr : axi_req_i.aw.addr;
    end
  end

  assign err_valid_o = r_err_valid;
  assign err_addr_o  = r_err_addr;
`else
  assign err_valid_o = 1'b0;
  assign err_addr_o  = '0;
`endif

  assign w_unused = ^{axi_req_i, err_clear_i};

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Bench for axi_decerr_slave: table-driven transactions, directed corner cases and
// a randomized phase, all checked against a queue-based transaction model.
module tb_axi_decerr_slave;
  import ariane_axi::*;

  localparam logic [63:0] PATTERN = 64'hBADC_AB1E_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  req_t        req;
  resp_t       resp;
  logic        err_valid;
  logic [63:0] err_addr;
  logic        err_clear;

  always #5 clk = ~clk;

  axi_decerr_slave dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .axi_req_i   (req),
    .axi_resp_o  (resp),
    .err_valid_o (err_valid),
    .err_addr_o  (err_addr),
    .err_clear_i (err_clear)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level model: expected R beats, pending B ids, open write burst.
  typedef struct { logic [4:0] id; logic last; } rbeat_t;
  rbeat_t      rq[$];
  logic [4:0]  bq[$];
  bit          w_open = 0;
  logic [4:0]  w_id = '0;
  bit          rdy_en = 0;
  bit          lg_v = 0;
  logic [63:0] lg_a = '0;
  bit          r_hold = 0;
  r_chan_t     r_prev;

  bit hs_aw_q, hs_ar_q, hs_w_q, hs_b_q, hs_r_q;
  bit r_done, b_done, b_prev;
  int beats_r, lasts_r, b_cnt, cyc_cnt, last_w_cyc, b_rise_cyc;
  logic [4:0] b_id_seen;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    bit e_aw, e_ar;
    @(negedge clk);
    hs_aw_q = 0; hs_ar_q = 0; hs_w_q = 0; hs_b_q = 0; hs_r_q = 0;
    if (rst_n) begin
      e_aw = rdy_en && !w_open && (bq.size() == 0);
      e_ar = rdy_en && (rq.size() == 0);
      chk("aw_ready", 128'(resp.aw_ready), 128'(e_aw));
      chk("ar_ready", 128'(resp.ar_ready), 128'(e_ar));
      chk("w_ready", 128'(resp.w_ready), 128'(w_open));
      chk("b_valid", 128'(resp.b_valid), 128'(bq.size() != 0));
      if (bq.size() != 0) begin
        chk("b_id", 128'(resp.b.id), 128'(bq[0]));
        chk("b_resp", 128'(resp.b.resp), 128'(2'b11));
      end
      chk("r_valid", 128'(resp.r_valid), 128'(rq.size() != 0));
      if (rq.size() != 0) begin
        chk("r_id", 128'(resp.r.id), 128'(rq[0].id));
        chk("r_last", 128'(resp.r.last), 128'(rq[0].last));
        chk("r_data", 128'(resp.r.data), 128'(PATTERN));
        chk("r_resp", 128'(resp.r.resp), 128'(2'b11));
      end
      if (r_hold) chk("r_stable", 128'(resp.r), 128'(r_prev));
`ifdef AXI_DECERR_LOG_EN
      chk("err_valid", 128'(err_valid), 128'(lg_v));
      chk("err_addr", 128'(err_addr), 128'(lg_a));
`else
      chk("err_valid_tied", 128'(err_valid), 128'(1'b0));
      chk("err_addr_tied", 128'(err_addr), 128'(64'd0));
`endif
      hs_aw_q = req.aw_valid && e_aw;
      hs_ar_q = req.ar_valid && e_ar;
      hs_w_q  = req.w_valid && w_open;
      hs_b_q  = req.b_ready && (bq.size() != 0);
      hs_r_q  = req.r_ready && (rq.size() != 0);
      r_hold  = resp.r_valid && !req.r_ready;
      r_prev  = resp.r;
      if (hs_r_q) begin
        beats_r++;
        if (resp.r.last) lasts_r++;
        if (rq[0].last) r_done = 1;
      end
      if (hs_w_q && req.w.last) last_w_cyc = cyc_cnt;
      if (resp.b_valid && !b_prev) begin
        b_rise_cyc = cyc_cnt;
        b_id_seen  = resp.b.id;
      end
      b_prev = resp.b_valid;
      if (hs_b_q) begin b_done = 1; b_cnt++; end
    end
    @(posedge clk);
    if (!rst_n) begin
      rq.delete(); bq.delete();
      w_open = 0; rdy_en = 0; r_hold = 0; b_prev = 0; lg_v = 0; lg_a = '0;
    end else begin
      if (hs_ar_q)
        for (int i = 0; i <= int'(req.ar.len); i++) begin
          rbeat_t bt;
          bt.id = req.ar.id;
          bt.last = (i == int'(req.ar.len));
          rq.push_back(bt);
        end
      if (hs_r_q) void'(rq.pop_front());
      if (hs_aw_q) begin w_open = 1; w_id = req.aw.id; end
      if (hs_w_q && req.w.last) begin w_open = 0; bq.push_back(w_id); end
      if (hs_b_q) void'(bq.pop_front());
`ifdef AXI_DECERR_LOG_EN
      if (err_clear) begin
        lg_v = 0; lg_a = '0;
      end else if (!lg_v && (hs_ar_q || hs_aw_q)) begin
        lg_v = 1;
        lg_a = hs_ar_q ? req.ar.addr : req.aw.addr;
      end
`endif
      rdy_en = 1;
    end
    cyc_cnt++;
    #1;
  endtask

  task automatic do_write(input logic [4:0] id, input int nbeats, input logic [63:0] addr);
    bit ok;
    req.b_ready = 1; req.aw_valid = 1; req.aw.id = id; req.aw.addr = addr;
    req.aw.len = 8'(nbeats - 1); req.aw.atop = 6'h21;
    b_done = 0;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin cyc(); ok = hs_aw_q; end
    chk("aw_accept_timeout", 128'(ok), 128'(1'b1));
    req.aw_valid = 0;
    for (int b = 0; b < nbeats; b++) begin
      req.w_valid = 1; req.w.last = (b == nbeats - 1); req.w.data = {$urandom, $urandom};
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin cyc(); ok = hs_w_q; end
      chk("w_accept_timeout", 128'(ok), 128'(1'b1));
    end
    req.w_valid = 0; req.w.last = 0;
    for (int t = 0; t < 20 && !b_done; t++) cyc();
    chk("b_timeout", 128'(b_done), 128'(1'b1));
  endtask

  task automatic do_read(input logic [4:0] id, input logic [7:0] len, input logic [63:0] addr,
                         input bit rand_ready);
    bit ok;
    req.ar_valid = 1; req.ar.id = id; req.ar.len = len; req.ar.addr = addr;
    req.r_ready = 1;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin cyc(); ok = hs_ar_q; end
    chk("ar_accept_timeout", 128'(ok), 128'(1'b1));
    req.ar_valid = 0;
    beats_r = 0; lasts_r = 0; r_done = 0;
    for (int t = 0; t < 4000 && !r_done; t++) begin
      if (rand_ready) req.r_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    req.r_ready = 0;
    chk("r_done_timeout", 128'(r_done), 128'(1'b1));
  endtask

  typedef struct { logic [4:0] id; int nbeats; logic [4:0] exp_bid; int exp_lat; } wvec_t;
  typedef struct { logic [4:0] id; logic [7:0] len; int exp_beats; } rvec_t;

  initial begin
    wvec_t wv[3];
    rvec_t rv[4];
    bit    ok;
    int    wb;

    wv[0] = '{id: 5'd5,  nbeats: 4, exp_bid: 5'd5,  exp_lat: 1};
    wv[1] = '{id: 5'd0,  nbeats: 1, exp_bid: 5'd0,  exp_lat: 1};
    wv[2] = '{id: 5'd31, nbeats: 3, exp_bid: 5'd31, exp_lat: 1};
    rv[0] = '{id: 5'd3,  len: 8'd0,  exp_beats: 1};
    rv[1] = '{id: 5'd7,  len: 8'd3,  exp_beats: 4};
    rv[2] = '{id: 5'd12, len: 8'd15, exp_beats: 16};
    rv[3] = '{id: 5'd30, len: 8'd1,  exp_beats: 2};

    req = '0; err_clear = 0; rst_n = 0;
    cyc(); cyc();
    chk("reset_resp", 128'(resp), 128'(0));
    chk("reset_err_valid", 128'(err_valid), 128'(1'b0));
    chk("reset_err_addr", 128'(err_addr), 128'(64'd0));
    rst_n = 1;
    cyc(); cyc();

    foreach (wv[i]) begin
      do_write(wv[i].id, wv[i].nbeats, 64'h6000_0000 + 64'(i));
      chk("w_b_id", 128'(b_id_seen), 128'(wv[i].exp_bid));
      chk("w_b_latency", 128'(b_rise_cyc - last_w_cyc), 128'(wv[i].exp_lat));
    end

    foreach (rv[i]) begin
      do_read(rv[i].id, rv[i].len, 64'h7000_0000 + 64'(i), 0);
      chk("r_beats", 128'(beats_r), 128'(rv[i].exp_beats));
      chk("r_last_count", 128'(lasts_r), 128'(1));
    end

    // Longest burst under random backpressure.
    do_read(5'd9, 8'd255, 64'h7100_0000, 1);
    chk("r255_beats", 128'(beats_r), 128'(256));
    chk("r255_last_count", 128'(lasts_r), 128'(1));

    // Concurrent AW len=1 and AR len=2.
    cyc();
    req.aw_valid = 1; req.aw.id = 5'd4; req.aw.len = 8'd1;
    req.ar_valid = 1; req.ar.id = 5'd8; req.ar.len = 8'd2;
    req.b_ready = 1; req.r_ready = 1;
    beats_r = 0; lasts_r = 0; r_done = 0; b_done = 0; b_cnt = 0;
    cyc();
    chk("conc_accept", 128'({hs_aw_q, hs_ar_q}), 128'(2'b11));
    req.aw_valid = 0; req.ar_valid = 0;
    wb = 0;
    for (int t = 0; t < 30 && !(r_done && b_done); t++) begin
      req.w_valid = (wb < 2); req.w.last = (wb == 1);
      cyc();
      if (hs_w_q) wb++;
    end
    req.w_valid = 0; req.w.last = 0; req.r_ready = 0;
    chk("conc_r_beats", 128'(beats_r), 128'(3));
    chk("conc_b_count", 128'(b_cnt), 128'(1));

    // Reset while beat 2 of 8 is on the bus.
    req.ar_valid = 1; req.ar.id = 5'd6; req.ar.len = 8'd7; req.r_ready = 1;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin cyc(); ok = hs_ar_q; end
    req.ar_valid = 0; beats_r = 0;
    for (int t = 0; t < 20 && beats_r < 1; t++) cyc();
    chk("pre_rst_rvalid", 128'(resp.r_valid), 128'(1'b1));
    rst_n = 0;
    #1;
    chk("rst_rvalid", 128'(resp.r_valid), 128'(1'b0));
    chk("rst_arready", 128'(resp.ar_ready), 128'(1'b0));
    chk("rst_r_last", 128'(resp.r.last), 128'(1'b0));
    req = '0;
    cyc(); cyc();
    rst_n = 1;
    cyc();
    do_read(5'd10, 8'd1, 64'h7200_0000, 0);
    chk("post_rst_beats", 128'(beats_r), 128'(2));

`ifdef AXI_DECERR_LOG_EN
    err_clear = 1; cyc(); err_clear = 0;
    do_read(5'd1, 8'd0, 64'h7000_0000, 0);
    do_write(5'd2, 1, 64'h6800_0000);
    chk("log_first_addr", 128'(err_addr), 128'(64'h7000_0000));
    chk("log_valid", 128'(err_valid), 128'(1'b1));
    err_clear = 1; cyc(); err_clear = 0;
    chk("log_cleared", 128'(err_valid), 128'(1'b0));
    do_write(5'd2, 1, 64'h6800_0000);
    chk("log_second_addr", 128'(err_addr), 128'(64'h6800_0000));
`endif

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      req.aw_valid = 1'($urandom_range(0, 1));
      req.aw.id    = 5'($urandom);
      req.aw.addr  = {$urandom, $urandom};
      req.aw.len   = 8'($urandom_range(0, 7));
      req.w_valid  = 1'($urandom_range(0, 1));
      req.w.last   = ($urandom_range(0, 2) == 0);
      req.w.data   = {$urandom, $urandom};
      req.b_ready  = 1'($urandom_range(0, 1));
      req.ar_valid = 1'($urandom_range(0, 1));
      req.ar.id    = 5'($urandom);
      req.ar.addr  = {$urandom, $urandom};
      req.ar.len   = 8'($urandom_range(0, 7));
      req.r_ready  = 1'($urandom_range(0, 1));
      err_clear    = ($urandom_range(0, 19) == 0);
      cyc();
    end

    req = '0; err_clear = 0;
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
